// File: rtl/seq_pattern_detector_if.sv
// rtl/seq_pattern_detector_if.sv - control, serial stream and status bundle for seq_pattern_detector
// Optional match_cnt member exists only when PATDET_COUNT_EN is defined.
interface seq_pattern_detector_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               load;
    logic [PAT_LEN-1:0] pattern;
    logic               mode_ovl;
    logic               in_valid;
    logic               in_bit;
    logic               armed;
    logic               det;
`ifdef PATDET_COUNT_EN
    logic [CNT_W-1:0]   match_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

    modport master (
        output load, pattern, mode_ovl, in_valid, in_bit,
        input  armed, det
`ifdef PATDET_COUNT_EN
        , input match_cnt
`endif
    );

    modport slave (
        input  load, pattern, mode_ovl, in_valid, in_bit,
        output armed, det
`ifdef PATDET_COUNT_EN
        , output match_cnt
`endif
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector, overlapping/non-overlapping
// Define PATDET_COUNT_EN to add the saturating match_cnt counter.
module seq_pattern_detector #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_pattern_detector_if.slave bus
);
    localparam int            FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    logic [PAT_LEN-1:0] pat_r;
    logic               ovl_r;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic               armed;
    logic               det;

    logic [PAT_LEN-1:0] hist_nxt;
    logic [FW-1:0]      fill_nxt;
    logic               match;

    // Look-ahead of the history after the current bit, so det lands one cycle after that bit.
    always_comb begin
        hist_nxt = {hist[PAT_LEN-2:0], bus.in_bit};
        fill_nxt = (fill == FULL) ? FULL : fill + FW'(1);
        match    = bus.in_valid && (hist_nxt == pat_r) && (fill_nxt == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pat_r <= '0;
            ovl_r <= 1'b0;
            hist  <= '0;
            fill  <= '0;
            armed <= 1'b0;
            det   <= 1'b0;
        end else begin
            det <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        pat_r <= bus.pattern;
                        ovl_r <= bus.mode_ovl;
                        hist  <= '0;
                        fill  <= '0;
                        armed <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL, RUN: begin
                    if (bus.load) begin
                        // Reload wins over the stream; the coincident bit is dropped.
                        pat_r <= bus.pattern;
                        ovl_r <= bus.mode_ovl;
                        hist  <= '0;
                        fill  <= '0;
                        state <= FILL;
                    end else if (bus.in_valid) begin
                        if (match) begin
                            det <= 1'b1;
                            if (ovl_r) begin
                                hist  <= hist_nxt;
                                fill  <= fill_nxt;
                                state <= RUN;
                            end else begin
                                hist  <= '0;
                                fill  <= '0;
                                state <= FILL;
                            end
                        end else begin
                            hist  <= hist_nxt;
                            fill  <= fill_nxt;
                            state <= (fill_nxt == FULL) ? RUN : FILL;
                        end
                    end
                end
                default: begin
                    pat_r <= '0;
                    ovl_r <= 1'b0;
                    hist  <= '0;
                    fill  <= '0;
                    armed <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.armed = armed;
    assign bus.det   = det;

`ifdef PATDET_COUNT_EN
    logic [CNT_W-1:0] match_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (det && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = match_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_pattern_detector_if #(.PAT_LEN(3), .CNT_W(8)) i3 ();
    seq_pattern_detector_if #(.PAT_LEN(4), .CNT_W(8)) i4 ();
    seq_pattern_detector_if #(.PAT_LEN(2), .CNT_W(2)) i2 ();

    seq_pattern_detector #(.PAT_LEN(3), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));
    seq_pattern_detector #(.PAT_LEN(4), .CNT_W(8)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));
    seq_pattern_detector #(.PAT_LEN(2), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i3.load = 0; i3.pattern = '0; i3.mode_ovl = 0; i3.in_valid = 0; i3.in_bit = 0;
        i4.load = 0; i4.pattern = '0; i4.mode_ovl = 0; i4.in_valid = 0; i4.in_bit = 0;
        i2.load = 0; i2.pattern = '0; i2.mode_ovl = 0; i2.in_valid = 0; i2.in_bit = 0;
        tick(); tick();
        checks++;
        if ({i3.armed, i3.det, i4.armed, i4.det, i2.armed, i2.det} !== 6'b0) begin
            $display("FAIL reset_outputs: got %b want 000000",
                     {i3.armed, i3.det, i4.armed, i4.det, i2.armed, i2.det});
            errors++;
        end
`ifdef PATDET_COUNT_EN
        checks++;
        if (i2.match_cnt !== 2'd0) begin
            $display("FAIL reset_cnt: got %0d want 0", i2.match_cnt);
            errors++;
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_overlap;
        logic [4:0] bits = 5'b10101;
        logic [4:0] exp  = 5'b00101;
        i3.pattern = 3'b101; i3.mode_ovl = 1'b1; i3.load = 1'b1;
        tick();
        i3.load = 1'b0;
        checks++;
        if (i3.armed !== 1'b1 || i3.det !== 1'b0) begin
            $display("FAIL ovl_load: armed=%b det=%b want armed=1 det=0", i3.armed, i3.det);
            errors++;
        end
        for (int k = 0; k < 5; k++) begin
            i3.in_valid = 1'b1; i3.in_bit = bits[4-k];
            tick();
            checks++;
            if (i3.det !== exp[4-k]) begin
                $display("FAIL ovl_det bit%0d: got %b want %b", k + 1, i3.det, exp[4-k]);
                errors++;
            end
        end
        i3.in_valid = 1'b0;
        tick();
        checks++;
        if (i3.det !== 1'b0) begin
            $display("FAIL ovl_idle: got %b want 0", i3.det);
            errors++;
        end
    endtask

    task automatic test_non_overlap;
        logic [4:0] bits = 5'b10101;
        logic [4:0] exp  = 5'b00100;
        i3.pattern = 3'b101; i3.mode_ovl = 1'b0; i3.load = 1'b1;
        tick();
        i3.load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i3.in_valid = 1'b1; i3.in_bit = bits[4-k];
            tick();
            checks++;
            if (i3.det !== exp[4-k]) begin
                $display("FAIL novl_det bit%0d: got %b want %b", k + 1, i3.det, exp[4-k]);
                errors++;
            end
        end
        i3.in_valid = 1'b0;
    endtask

    task automatic test_gap;
        i4.pattern = 4'b1100; i4.mode_ovl = 1'b1; i4.load = 1'b1;
        tick();
        i4.load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i4.in_valid = 1'b1; i4.in_bit = 1'b1;
            tick();
            checks++;
            if (i4.det !== 1'b0) begin
                $display("FAIL gap_lead bit%0d: got %b want 0", k + 1, i4.det);
                errors++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            i4.in_valid = 1'b0; i4.in_bit = 1'b0;
            tick();
            checks++;
            if (i4.det !== 1'b0) begin
                $display("FAIL gap_hold cycle%0d: got %b want 0", k + 1, i4.det);
                errors++;
            end
        end
        i4.in_valid = 1'b1; i4.in_bit = 1'b0;
        tick();
        checks++;
        if (i4.det !== 1'b0) begin
            $display("FAIL gap_bit3: got %b want 0", i4.det);
            errors++;
        end
        tick();
        checks++;
        if (i4.det !== 1'b1) begin
            $display("FAIL gap_match: got %b want 1", i4.det);
            errors++;
        end
        i4.in_valid = 1'b0;
        tick();
        checks++;
        if (i4.det !== 1'b0) begin
            $display("FAIL gap_pulse_width: got %b want 0", i4.det);
            errors++;
        end
    endtask

    task automatic test_reload;
        logic [5:0] bits = 6'b110110;
        logic [5:0] exp  = 6'b000001;
        i4.pattern = 4'b0110; i4.mode_ovl = 1'b1; i4.load = 1'b1;
        i4.in_valid = 1'b1; i4.in_bit = 1'b0;
        tick();
        i4.load = 1'b0;
        checks++;
        if (i4.det !== 1'b0 || i4.armed !== 1'b1) begin
            $display("FAIL reload_load: det=%b armed=%b want det=0 armed=1", i4.det, i4.armed);
            errors++;
        end
        for (int k = 0; k < 6; k++) begin
            i4.in_valid = 1'b1; i4.in_bit = bits[5-k];
            tick();
            checks++;
            if (i4.det !== exp[5-k] || i4.armed !== 1'b1) begin
                $display("FAIL reload_det bit%0d: det=%b armed=%b want det=%b armed=1",
                         k + 1, i4.det, i4.armed, exp[5-k]);
                errors++;
            end
        end
        i4.in_valid = 1'b0;
    endtask

    task automatic test_reset_race;
        logic [2:0] bits = 3'b101;
        logic [2:0] exp  = 3'b001;
        i3.pattern = 3'b101; i3.mode_ovl = 1'b1; i3.load = 1'b1;
        tick();
        i3.load = 1'b0;
        i3.in_valid = 1'b1; i3.in_bit = 1'b1; tick();
        i3.in_bit = 1'b0; tick();
        i3.in_bit = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (i3.armed !== 1'b0) begin
            $display("FAIL rst_async_armed: got %b want 0", i3.armed);
            errors++;
        end
        tick();
        rst = 1'b0;
        checks++;
        if (i3.det !== 1'b0 || i3.armed !== 1'b0) begin
            $display("FAIL rst_race: det=%b armed=%b want 0 0", i3.det, i3.armed);
            errors++;
        end
        for (int k = 0; k < 3; k++) begin
            i3.in_valid = 1'b1; i3.in_bit = bits[2-k];
            tick();
            checks++;
            if (i3.det !== 1'b0 || i3.armed !== 1'b0) begin
                $display("FAIL rst_idle bit%0d: det=%b armed=%b want 0 0", k + 1, i3.det, i3.armed);
                errors++;
            end
        end
        i3.in_valid = 1'b0; i3.load = 1'b1;
        tick();
        i3.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i3.in_valid = 1'b1; i3.in_bit = bits[2-k];
            tick();
            checks++;
            if (i3.det !== exp[2-k]) begin
                $display("FAIL rst_recover bit%0d: got %b want %b", k + 1, i3.det, exp[2-k]);
                errors++;
            end
        end
        i3.in_valid = 1'b0;
    endtask

    task automatic test_count;
        logic [5:0] exp_det = 6'b011111;
        int         exp_cnt[6] = '{0, 0, 1, 2, 3, 3};
        int         pulses = 0;
        i2.pattern = 2'b11; i2.mode_ovl = 1'b1; i2.load = 1'b1;
        tick();
        i2.load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i2.in_valid = 1'b1; i2.in_bit = 1'b1;
            tick();
            if (i2.det === 1'b1) pulses++;
            checks++;
            if (i2.det !== exp_det[5-k]) begin
                $display("FAIL cnt_det bit%0d: got %b want %b", k + 1, i2.det, exp_det[5-k]);
                errors++;
            end
`ifdef PATDET_COUNT_EN
            checks++;
            if (int'(i2.match_cnt) !== exp_cnt[k]) begin
                $display("FAIL cnt_value bit%0d: got %0d want %0d", k + 1, i2.match_cnt, exp_cnt[k]);
                errors++;
            end
`endif
        end
        i2.in_valid = 1'b0;
        tick();
        checks++;
        if (pulses !== 5 || i2.det !== 1'b0) begin
            $display("FAIL cnt_pulses: got %0d pulses det=%b want 5 pulses det=0", pulses, i2.det);
            errors++;
        end
        i2.load = 1'b1;
        tick();
        i2.load = 1'b0;
        checks++;
        if (i2.armed !== 1'b1 || i2.det !== 1'b0) begin
            $display("FAIL cnt_reload: armed=%b det=%b want 1 0", i2.armed, i2.det);
            errors++;
        end
`ifdef PATDET_COUNT_EN
        checks++;
        if (i2.match_cnt !== 2'd3) begin
            $display("FAIL cnt_kept_on_load: got %0d want 3", i2.match_cnt);
            errors++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_reload();
        test_reset_race();
        test_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
